pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//  Flow-controlled pipeline stage register: the receiving end of a valid/ready stage link.
//  Accepts a word from the upstream stage and presents it to the downstream stage one cycle later.
//  Absorbs downstream backpressure with a 2-entry (main + skid) buffer, so in_ready never depends combinationally on out_ready.
//  Sits between MCU pipeline stages where a plain always-load register cannot stall.
// PARAMETERS
//  WIDTH  32  payload width in bits
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-high
//  flush      in   1      sync discard of all buffered words (branch/exception)
//  in_valid   in   1      upstream word valid
//  in_ready   out  1      stage can accept; registered (state decode only)
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      main entry holds a word
//  out_ready  in   1      downstream accepts
//  out_data   out  WIDTH  main entry payload
//  stall_cnt  out  16     only with PIPE_SKID_STATS_EN (see CONFIGURATION)
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset: state EMPTY; in_ready=1; out_valid=0; out_data=0; skid data=0.
//  - Latency: word accepted at edge N appears on out_data/out_valid after edge N (1 cycle).
//  - States: EMPTY (0 words), ONE (main full), TWO (main+skid full).
//      EMPTY: in_fire -> ONE, main<=in_data.
//      ONE : in_fire & out_fire  -> ONE, main<=in_data.
//            in_fire & !out_ready -> TWO, skid<=in_data.
//            !in_fire & out_fire  -> EMPTY.
//            otherwise hold.
//      TWO : in_ready=0; out_fire -> ONE, main<=skid; otherwise hold.
//  - in_ready = (state != TWO). out_valid = (state != EMPTY).
//  - Stability: while out_valid & !out_ready, out_data stays unchanged.
//  - Order: strict FIFO; no word is dropped or duplicated except by flush/reset.
//  - flush: next state EMPTY regardless of in_fire/out_fire in the same cycle.
//      The word offered in that cycle is discarded; the upstream handshake still completes.
//      Data regs keep stale values (not observable: out_valid=0).
//  - Priority: reset > flush > normal transitions.
//  - Reset mid-operation discards both entries; no partial transfer.
// CONFIGURATION
//  PIPE_SKID_STATS_EN defined:
//    - stall_cnt port exists; 16-bit counter, +1 each cycle with out_valid & !out_ready.
//    - Saturates at 16'hFFFF; cleared by reset only (not by flush).
//  Not defined: port and counter are absent; behaviour otherwise identical.
// STRUCTURE
//  - Shared header pipe_defs.vh: state encodings PIPE_EMPTY=2'd0, PIPE_ONE=2'd1, PIPE_TWO=2'd2.
//    Stall counter width 16 is a named constant in the same header.
//  - Sub-module flopenr (WIDTH, sync reset, load enable): one instance each for the main and skid data registers.
//  - The state machine lives in this module.
// TESTING
//  1. Reset, then in_valid=1 in_data=32'hA5 with out_ready=1:
//       out_valid=1 and out_data=32'hA5 one cycle later; in_ready stays 1.
//  2. Streaming with out_ready=1, words 1..8 back-to-back:
//       outputs 1..8 in order at one word per cycle; state never reaches TWO.
//  3. out_ready=0 while sending 3 words 10,11,12:
//       10 in main, 11 in skid, in_ready=0, 12 held upstream;
//       raise out_ready: 10,11,12 emerge in order with no loss.
//  4. State TWO (main=5, skid=6), assert flush with in_valid=1 in_data=7:
//       next cycle out_valid=0, in_ready=1; word 7 never appears.
//  5. Reset asserted in TWO with flush=1 and in_valid=1:
//       next cycle out_valid=0, out_data=0, in_ready=1.
//  6. PIPE_SKID_STATS_EN: hold out_ready=0 with out_valid=1 for 70000 cycles:
//       stall_cnt=16'hFFFF; flush leaves it unchanged; reset clears it to 0.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipe_skid_reg stage: occupancy state encodings and stall counter width.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } pipe_state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_skid_reg_flopenr.sv
// Load-enabled data register with synchronous active-high reset to zero.
module flopenr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage with a main + skid entry so in_ready is a pure state decode.
// Optional stall statistics counter enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  pipe_state_t      state_reg;
  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             skid_load;
  logic [WIDTH-1:0] main_next;
  logic [WIDTH-1:0] skid_reg;

  assign in_ready  = (state_reg != PIPE_TWO);
  assign out_valid = (state_reg != PIPE_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Data loads are suppressed on flush; the entries just go stale behind out_valid=0.
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_next = in_data;
    if (!flush) begin
      unique case (state_reg)
        PIPE_EMPTY: main_load = in_fire;
        PIPE_ONE: begin
          main_load = in_fire & out_fire;
          skid_load = in_fire & ~out_ready;
        end
        PIPE_TWO: begin
          main_load = out_fire;
          main_next = skid_reg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_reg <= PIPE_EMPTY;
    end else begin
      unique case (state_reg)
        PIPE_EMPTY: if (in_fire) state_reg <= PIPE_ONE;
        PIPE_ONE: begin
          if (in_fire && !out_ready)      state_reg <= PIPE_TWO;
          else if (!in_fire && out_fire)  state_reg <= PIPE_EMPTY;
        end
        PIPE_TWO: if (out_fire) state_reg <= PIPE_ONE;
        default: state_reg <= PIPE_EMPTY;
      endcase
    end
  end

  flopenr #(.WIDTH(WIDTH)) u_main (
    .clk  (clk),
    .reset(reset),
    .en   (main_load),
    .d    (main_next),
    .q    (out_data)
  );

  flopenr #(.WIDTH(WIDTH)) u_skid (
    .clk  (clk),
    .reset(reset),
    .en   (skid_load),
    .d    (in_data),
    .q    (skid_reg)
  );

`ifdef PIPE_SKID_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  // Saturating; flush deliberately leaves the count alone.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_reg <= '0;
    else if (out_valid && !out_ready && stall_cnt_reg != {STALL_CNT_W{1'b1}})
      stall_cnt_reg <= stall_cnt_reg + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg; stall counter checks run when PIPE_SKID_STATS_EN is defined.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_SKID_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
`ifdef PIPE_SKID_STATS_EN
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    reset = 1'b0;

    // 1: single word, one-cycle latency
    in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
    step();
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data", out_data, 32'hA5);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("t1_drain", {31'd0, out_valid}, 32'd0);

    // 2: back-to-back streaming, never reaches TWO
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i;
      step();
      chk($sformatf("t2_data%0d", i), out_data, i);
      chk($sformatf("t2_rdy%0d", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("t2_drain", {31'd0, out_valid}, 32'd0);

    // 3: backpressure fills main and skid, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd10;
    step();
    chk("t3_main10", out_data, 32'd10);
    in_data = 32'd11;
    step();
    chk("t3_full_rdy", {31'd0, in_ready}, 32'd0);
    chk("t3_stable10a", out_data, 32'd10);
    in_data = 32'd12;
    step();
    chk("t3_held_rdy", {31'd0, in_ready}, 32'd0);
    chk("t3_stable10b", out_data, 32'd10);
    out_ready = 1'b1;
    step();
    chk("t3_out11", out_data, 32'd11);
    chk("t3_rdy_back", {31'd0, in_ready}, 32'd1);
    step();
    chk("t3_out12", out_data, 32'd12);
    chk("t3_valid12", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("t3_drain", {31'd0, out_valid}, 32'd0);

    // 4: flush from TWO drops both entries and the offered word
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd5;
    step();
    in_data = 32'd6;
    step();
    chk("t4_two_rdy", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; in_data = 32'd7;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_flush_rdy", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("t4_no7", {31'd0, out_valid}, 32'd0);

    // 4b: flush from ONE while a word is accepted; that word is discarded
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd8;
    step();
    flush = 1'b1; in_data = 32'd9;
    step();
    flush = 1'b0;
    chk("t4b_flush_valid", {31'd0, out_valid}, 32'd0);
    in_data = 32'd3;
    step();
    in_valid = 1'b0;
    chk("t4b_next_word", out_data, 32'd3);
    out_ready = 1'b1;
    step();
    chk("t4b_drain", {31'd0, out_valid}, 32'd0);

    // 5: reset wins over flush while in TWO
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd20;
    step();
    in_data = 32'd21;
    step();
    reset = 1'b1; flush = 1'b1; in_data = 32'd22;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_data", out_data, 32'd0);
    chk("t5_rdy", {31'd0, in_ready}, 32'd1);

`ifdef PIPE_SKID_STATS_EN
    // 6: saturating stall counter
    in_valid = 1'b1; in_data = 32'd30; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("t6_saturated", {16'd0, stall_cnt}, 32'h0000FFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_flush_keeps", {16'd0, stall_cnt}, 32'h0000FFFF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_reset_clears", {16'd0, stall_cnt}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
